// File: rtl/start_ack_ctrl_pkg.sv
// Shared types and default sizing for the Start/Ack run handshake responder.
package start_ack_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        INIT = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } run_state_t;

    localparam int CYCLE_W_DEFAULT = 16;
    localparam int TIMEOUT_DEFAULT = 5000;

endpackage

// File: rtl/run_watchdog.sv
// Saturating run-cycle counter with a registered look-ahead compare that
// flags when the next counted cycle will reach the watchdog limit.
module run_watchdog
    import start_ack_ctrl_pkg::*;
#(
    parameter int CYCLE_W = CYCLE_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_count,
    output logic [CYCLE_W-1:0] o_count,
    output logic               o_expire
);

    localparam logic [CYCLE_W-1:0] LAST_BEFORE_EXPIRE = CYCLE_W'(TIMEOUT - 1);
    localparam logic [CYCLE_W-1:0] ONE                = CYCLE_W'(1);

    logic [CYCLE_W-1:0] r_count;
    logic [CYCLE_W-1:0] w_countNext;
    logic               r_expire;

    always_comb begin
        w_countNext = r_count;
        if (i_clear) begin
            w_countNext = '0;
        end else if (i_count && (r_count != '1)) begin
            w_countNext = r_count + ONE;
        end
    end

    // Expire is high while the count sits one below the limit, so the FSM sees
    // it on exactly the edge whose increment lands on TIMEOUT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count  <= '0;
            r_expire <= 1'b0;
        end else begin
            r_count  <= w_countNext;
            r_expire <= (w_countNext == LAST_BEFORE_EXPIRE);
        end
    end

    assign o_count  = r_count;
    assign o_expire = r_expire;

endmodule

// File: rtl/start_ack_ctrl.sv
// Responder side of the Start/Ack run handshake: load window, core init/run
// sequencing, and a sticky done flag raised on halt or watchdog expiry.
module start_ack_ctrl
    import start_ack_ctrl_pkg::*;
#(
    parameter int CYCLE_W = CYCLE_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Halt,
    output logic               MemLoadEn,
    output logic               CoreInit,
    output logic               CoreRun,
    output logic               Ack,
    output logic               Timeout,
    output logic [CYCLE_W-1:0] CycleCount
);

    run_state_t r_state;
    run_state_t w_stateNext;
    logic       w_timeoutNext;
    logic       w_expire;
    logic       w_countClear;
    logic       w_countEn;

    logic r_memLoadEn;
    logic r_coreInit;
    logic r_coreRun;
    logic r_ack;
    logic r_timeout;

    // Abort beats halt, halt beats the watchdog.
    always_comb begin
        w_stateNext   = r_state;
        w_timeoutNext = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) w_stateNext = LOAD;
            end
            LOAD: begin
                if (!Start) w_stateNext = INIT;
            end
            INIT: begin
                w_stateNext = RUN;
            end
            RUN: begin
                if (Start) begin
                    w_stateNext = LOAD;
                end else if (Halt) begin
                    w_stateNext = DONE;
                end else if (w_expire) begin
                    w_stateNext   = DONE;
                    w_timeoutNext = 1'b1;
                end
            end
            DONE: begin
                if (Start) begin
                    w_stateNext = LOAD;
                end else begin
                    w_timeoutNext = r_timeout;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign w_countClear = (w_stateNext == INIT);
    assign w_countEn    = (r_state == RUN);

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= IDLE;
            r_memLoadEn <= 1'b0;
            r_coreInit  <= 1'b0;
            r_coreRun   <= 1'b0;
            r_ack       <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_memLoadEn <= (w_stateNext == LOAD);
            r_coreInit  <= (w_stateNext == INIT);
            r_coreRun   <= (w_stateNext == RUN);
            r_ack       <= (w_stateNext == DONE);
            r_timeout   <= w_timeoutNext;
        end
    end

    run_watchdog #(
        .CYCLE_W (CYCLE_W),
        .TIMEOUT (TIMEOUT)
    ) u_run_watchdog (
        .i_clk    (Clk),
        .i_rst_n  (Reset),
        .i_clear  (w_countClear),
        .i_count  (w_countEn),
        .o_count  (CycleCount),
        .o_expire (w_expire)
    );

    assign MemLoadEn = r_memLoadEn;
    assign CoreInit  = r_coreInit;
    assign CoreRun   = r_coreRun;
    assign Ack       = r_ack;
    assign Timeout   = r_timeout;

endmodule

// File: tb/tb_start_ack_ctrl.sv
// Scoreboard bench for start_ack_ctrl: each run pushes its predicted outcome,
// which is popped and compared once the run ends (done, abort or reset).
module tb_start_ack_ctrl;

    localparam int TB_CYCLE_W = 16;
    localparam int TB_TIMEOUT = 20;

    logic                  Clk;
    logic                  Reset;
    logic                  Start;
    logic                  Halt;
    logic                  MemLoadEn;
    logic                  CoreInit;
    logic                  CoreRun;
    logic                  Ack;
    logic                  Timeout;
    logic [TB_CYCLE_W-1:0] CycleCount;

    typedef struct {
        int ack;
        int timeout;
        int count;
        int runCycles;
        int memLoad;
    } expRes_t;

    expRes_t expQ[$];
    int      checks = 0;
    int      errors = 0;

    start_ack_ctrl #(
        .CYCLE_W (TB_CYCLE_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Halt       (Halt),
        .MemLoadEn  (MemLoadEn),
        .CoreInit   (CoreInit),
        .CoreRun    (CoreRun),
        .Ack        (Ack),
        .Timeout    (Timeout),
        .CycleCount (CycleCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one complete run; a nonzero abortCycle/resetCycle interrupts it on that RUN cycle.
    task automatic applyStimulus(input int loadCycles, input int haltCycle, input int abortCycle, input int resetCycle);
        expRes_t exp;
        int      runCount;
        int      initPulses;
        bit      done;

        if (resetCycle > 0)
            exp = '{ack: 0, timeout: 0, count: 0, runCycles: resetCycle, memLoad: 0};
        else if (abortCycle > 0)
            exp = '{ack: 0, timeout: 0, count: abortCycle, runCycles: abortCycle, memLoad: 1};
        else if (haltCycle > 0 && haltCycle <= TB_TIMEOUT)
            exp = '{ack: 1, timeout: 0, count: haltCycle, runCycles: haltCycle, memLoad: 0};
        else
            exp = '{ack: 1, timeout: 1, count: TB_TIMEOUT, runCycles: TB_TIMEOUT, memLoad: 0};
        expQ.push_back(exp);

        Start = 1'b1;
        for (int i = 0; i < loadCycles; i++) begin
            @(negedge Clk);
            if (i == 0) begin
                checkOutput("loadAckClear", 32'(Ack), 32'd0);
                checkOutput("loadTimeoutClear", 32'(Timeout), 32'd0);
            end
            checkOutput("memLoadEn", 32'(MemLoadEn), 32'd1);
        end
        Start = 1'b0;
        @(negedge Clk);
        checkOutput("coreInit", 32'(CoreInit), 32'd1);
        checkOutput("initNoRun", 32'(CoreRun), 32'd0);
        checkOutput("initCountZero", 32'(CycleCount), 32'd0);

        runCount   = 0;
        initPulses = 0;
        done       = 1'b0;
        for (int cyc = 0; cyc < TB_TIMEOUT + 10 && !done; cyc++) begin
            @(negedge Clk);
            Halt = 1'b0;
            if (CoreInit) initPulses++;
            if (CoreRun) begin
                runCount++;
                if (runCount == resetCycle) begin
                    Start = 1'b0;
                    #2 Reset = 1'b0;
                    #1 done = 1'b1;
                end else begin
                    if (runCount == haltCycle)  Halt  = 1'b1;
                    if (runCount == abortCycle) Start = 1'b1;
                end
            end else begin
                done = 1'b1;
            end
        end
        if (!done) checkOutput("runBound", 32'd0, 32'd1);

        exp = expQ.pop_front();
        checkOutput("ack", 32'(Ack), 32'(exp.ack));
        checkOutput("timeout", 32'(Timeout), 32'(exp.timeout));
        checkOutput("cycleCount", 32'(CycleCount), 32'(exp.count));
        checkOutput("runCycles", 32'(runCount), 32'(exp.runCycles));
        checkOutput("memLoadAfter", 32'(MemLoadEn), 32'(exp.memLoad));
        checkOutput("coreRunAfter", 32'(CoreRun), 32'd0);
        checkOutput("initSinglePulse", 32'(initPulses), 32'd0);

        if (resetCycle > 0) begin
            @(negedge Clk);
            Reset = 1'b1;
        end
    endtask

    initial begin
        int ackLow;
        int runHigh;

        Reset = 1'b0;
        Start = 1'b0;
        Halt  = 1'b0;
        #8;
        checkOutput("rstMemLoadEn", 32'(MemLoadEn), 32'd0);
        checkOutput("rstCoreInit", 32'(CoreInit), 32'd0);
        checkOutput("rstCoreRun", 32'(CoreRun), 32'd0);
        checkOutput("rstAck", 32'(Ack), 32'd0);
        checkOutput("rstTimeout", 32'(Timeout), 32'd0);
        checkOutput("rstCycleCount", 32'(CycleCount), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("idleMemLoadEn", 32'(MemLoadEn), 32'd0);
        checkOutput("idleAck", 32'(Ack), 32'd0);
        checkOutput("idleCoreRun", 32'(CoreRun), 32'd0);

        applyStimulus(3, 7, 0, 0);

        // Ack must stay high and count frozen through DONE, even with a stray Halt.
        ackLow  = 0;
        runHigh = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            Halt = (i == 5);
            if (!Ack) ackLow++;
            if (CoreRun) runHigh++;
        end
        Halt = 1'b0;
        checkOutput("ackSticky", 32'(ackLow), 32'd0);
        checkOutput("doneNoRun", 32'(runHigh), 32'd0);
        checkOutput("doneCountFrozen", 32'(CycleCount), 32'd7);

        applyStimulus(2, 0, 0, 0);
        applyStimulus(1, TB_TIMEOUT, 0, 0);
        applyStimulus(2, 5, 5, 0);
        applyStimulus(2, 3, 0, 0);
        applyStimulus(2, 0, 0, 4);
        applyStimulus(2, 5, 0, 0);
        applyStimulus(2, 2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got 1, expected 0");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
